// File: rtl/iob_cache_line_resp_pkg.sv
// Shared state encodings and width helpers for the cache line-wide backend responder.
package iob_cache_line_resp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Line width from word width and log2 words per line.
    function automatic int unsigned line_w(input int unsigned data_w, input int unsigned word_offset_w);
        return data_w << word_offset_w;
    endfunction

endpackage

// File: rtl/iob_cache_line_asm.sv
// Line register: bulk load of a full line, or one word slot written at an index.
module iob_cache_line_asm
    import iob_cache_line_resp_pkg::*;
#(
    parameter  int unsigned DATA_W        = 32,
    parameter  int unsigned WORD_OFFSET_W = 2,
    localparam int unsigned LINE_W        = line_w(DATA_W, WORD_OFFSET_W)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_load,
    input  logic [LINE_W-1:0]        i_line,
    input  logic                     i_we,
    input  logic [WORD_OFFSET_W-1:0] i_idx,
    input  logic [DATA_W-1:0]        i_word,
    output logic [LINE_W-1:0]        o_line
);

    logic [LINE_W-1:0] r_line;

    // Bulk load wins over a slot write; the two never coincide in the responder.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_line;
        end else if (i_we) begin
            r_line[i_idx*DATA_W +: DATA_W] <= i_word;
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/iob_cache_line_resp.sv
// Serialises one line-wide buffer request into BLKSZ word requests on the backend port;
// reads are reassembled and answered with a single rvalid pulse.
module iob_cache_line_resp
    import iob_cache_line_resp_pkg::*;
#(
    parameter  int unsigned DATA_W        = 32,
    parameter  int unsigned WORD_OFFSET_W = 2,
    parameter  int unsigned BUF_ADDR_W    = 28,
    localparam int unsigned NBYTES        = DATA_W / 8,
    localparam int unsigned NBYTES_W      = $clog2(NBYTES),
    localparam int unsigned LINE_W        = line_w(DATA_W, WORD_OFFSET_W),
    localparam int unsigned BE_ADDR_W     = BUF_ADDR_W + WORD_OFFSET_W + NBYTES_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  buf_iob_avalid_i,
    input  logic [BUF_ADDR_W-1:0] buf_iob_addr_i,
    input  logic [LINE_W-1:0]     buf_iob_wdata_i,
    input  logic [LINE_W/8-1:0]   buf_iob_wstrb_i,
    output logic                  buf_iob_ready_o,
    output logic [LINE_W-1:0]     buf_iob_rdata_o,
    output logic                  buf_iob_rvalid_o,

    output logic                  be_iob_avalid_o,
    output logic [BE_ADDR_W-1:0]  be_iob_addr_o,
    output logic [DATA_W-1:0]     be_iob_wdata_o,
    output logic [NBYTES-1:0]     be_iob_wstrb_o,
    input  logic                  be_iob_ready_i,
    input  logic [DATA_W-1:0]     be_iob_rdata_i,
    input  logic                  be_iob_rvalid_i,

    output logic                  busy_o
);

    localparam int unsigned BLKSZ = 1 << WORD_OFFSET_W;
    localparam int unsigned CNT_W = WORD_OFFSET_W + 1;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [CNT_W-1:0]         r_issue_cnt;
    logic [CNT_W-1:0]         w_issue_nxt;
    logic [CNT_W-1:0]         r_ret_cnt;
    logic [CNT_W-1:0]         w_ret_nxt;
    logic [BUF_ADDR_W-1:0]    r_addr;
    logic [LINE_W/8-1:0]      r_wstrb;
    logic [LINE_W-1:0]        r_rdata;
    logic [LINE_W-1:0]        w_line;

    logic                     w_accept;
    logic                     w_issue_fire;
    logic                     w_ret_fire;
    logic                     w_last_ret;
    logic [WORD_OFFSET_W-1:0] w_issue_idx;
    logic [WORD_OFFSET_W-1:0] w_ret_idx;

    assign w_issue_idx  = r_issue_cnt[WORD_OFFSET_W-1:0];
    assign w_ret_idx    = r_ret_cnt[WORD_OFFSET_W-1:0];
    assign w_accept     = buf_iob_avalid_i & (r_state == ST_IDLE);
    assign w_issue_fire = be_iob_avalid_o & be_iob_ready_i;
    assign w_ret_fire   = (r_state == ST_READ) & be_iob_rvalid_i;
    assign w_last_ret   = w_ret_fire & (r_ret_cnt == CNT_W'(BLKSZ - 1));

    // Next-state and counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_issue_nxt = r_issue_cnt;
        w_ret_nxt   = r_ret_cnt;
        case (r_state)
            ST_IDLE: begin
                if (buf_iob_avalid_i) begin
                    w_issue_nxt = '0;
                    w_ret_nxt   = '0;
                    w_state_nxt = (|buf_iob_wstrb_i) ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (be_iob_ready_i) begin
                    w_issue_nxt = r_issue_cnt + CNT_W'(1);
                    if (r_issue_cnt == CNT_W'(BLKSZ - 1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (w_issue_fire) begin
                    w_issue_nxt = r_issue_cnt + CNT_W'(1);
                end
                if (w_ret_fire) begin
                    w_ret_nxt = r_ret_cnt + CNT_W'(1);
                end
                if (w_last_ret) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters, captured request, and the published read line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_addr      <= '0;
            r_wstrb     <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_issue_cnt <= w_issue_nxt;
            r_ret_cnt   <= w_ret_nxt;
            if (w_accept) begin
                r_addr  <= buf_iob_addr_i;
                r_wstrb <= buf_iob_wstrb_i;
            end
            // Returns arrive in order, so the final word always fills the top slot.
            if (w_last_ret) begin
                r_rdata <= {be_iob_rdata_i, w_line[LINE_W-DATA_W-1:0]};
            end
        end
    end

    iob_cache_line_asm #(
        .DATA_W        (DATA_W),
        .WORD_OFFSET_W (WORD_OFFSET_W)
    ) u_line (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_load (w_accept),
        .i_line (buf_iob_wdata_i),
        .i_we   (w_ret_fire),
        .i_idx  (w_ret_idx),
        .i_word (be_iob_rdata_i),
        .o_line (w_line)
    );

    assign buf_iob_ready_o  = (r_state == ST_IDLE);
    assign buf_iob_rvalid_o = (r_state == ST_RESP);
    assign buf_iob_rdata_o  = r_rdata;
    assign busy_o           = (r_state != ST_IDLE);

    assign be_iob_avalid_o = (r_state == ST_WRITE) |
                             ((r_state == ST_READ) & (r_issue_cnt < CNT_W'(BLKSZ)));
    assign be_iob_addr_o   = {r_addr, w_issue_idx, {NBYTES_W{1'b0}}};
    assign be_iob_wdata_o  = w_line[w_issue_idx*DATA_W +: DATA_W];
    assign be_iob_wstrb_o  = (r_state == ST_WRITE) ? r_wstrb[w_issue_idx*NBYTES +: NBYTES] : '0;

endmodule
